srt_qconv: RTL and testbench

Post-processing stage that sits directly downstream of the SRT divider core. It accepts the radix-4 signed quotient digit stream and the final partial remainder, and performs on-the-fly conversion of the digits into a binary quotient. It then applies the final negative-remainder correction, de-normalizes the remainder by the divider's normalization shift, and presents Q/R with a one-cycle DONE strobe.

---
 rtl/srt_qconv.sv | 175 +++++++++++++++++
 tb/tb_srt_qconv.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/srt_qconv.sv
// SRT radix-4 quotient on-the-fly conversion, remainder correction
// and de-normalization stage.
module srt_qconv #(
  parameter int W    = 64,
  parameter int NDIG = W/2,
  parameter int SW   = 7
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  input  logic [W-1:0]  DSR_N,
  input  logic [SW-1:0] SHAMT,
  input  logic          DIG_VALID,
  input  logic [2:0]    DIG,
  input  logic          DIG_LAST,
  input  logic [W:0]    REM_IN,
  output logic          DIG_READY,
  output logic          BUSY,
  output logic [W-1:0]  Q,
  output logic [W-1:0]  R,
  output logic          DONE,
  output logic          ERR
);

  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_CORR, S_SHIFT, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [W+1:0]  qa, qa_n, qb, qb_n;
  logic [W:0]    rem, rem_n;
  logic [W-1:0]  dsr, dsr_n;
  logic [SW-1:0] shamt, shamt_n, sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n;
  logic [W-1:0]  q_n, r_n;

  logic [SW-1:0] shamt_sat;
  logic [W+1:0]  qa_d, qb_d, qa_c;
  logic [W:0]    rem_c, rem_sh;
  logic          ill, at_ndig;

  assign shamt_sat = (SHAMT > SW'(W)) ? SW'(W) : SHAMT;
  assign at_ndig   = (cnt == CW'(NDIG - 1));

  // Negative remainder means the quotient overshot by one: take QB.
  assign qa_c   = rem[W] ? qb : qa;
  assign rem_c  = rem[W] ? rem + {1'b0, dsr} : rem;
  assign rem_sh = rem >> 1;

  always_comb begin
    ill  = 1'b0;
    qa_d = {qa[W-1:0], 2'b00};
    qb_d = {qb[W-1:0], 2'b11};
    unique case (DIG)
      3'b000: ;
      3'b001: begin
        qa_d = {qa[W-1:0], 2'b01};
        qb_d = {qa[W-1:0], 2'b00};
      end
      3'b010: begin
        qa_d = {qa[W-1:0], 2'b10};
        qb_d = {qa[W-1:0], 2'b01};
      end
      3'b101: begin
        qa_d = {qb[W-1:0], 2'b11};
        qb_d = {qb[W-1:0], 2'b10};
      end
      3'b110: begin
        qa_d = {qb[W-1:0], 2'b10};
        qb_d = {qb[W-1:0], 2'b01};
      end
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    qa_n    = qa;
    qb_n    = qb;
    rem_n   = rem;
    dsr_n   = dsr;
    shamt_n = shamt;
    sh_n    = sh;
    cnt_n   = cnt;
    err_n   = ERR;
    q_n     = Q;
    r_n     = R;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          dsr_n   = DSR_N;
          shamt_n = shamt_sat;
          qa_n    = '0;
          qb_n    = '1;
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (DIG_VALID) begin
          qa_n  = qa_d;
          qb_n  = qb_d;
          cnt_n = cnt + 1'b1;
          if (ill) err_n = 1'b1;
          if (DIG_LAST || at_ndig) begin
            rem_n   = REM_IN;
            state_n = S_CORR;
            if (DIG_LAST != at_ndig) err_n = 1'b1;
          end
        end
      end
      S_CORR: begin
        qa_n  = qa_c;
        rem_n = rem_c;
        if (qa_c[W+1:W] != 2'b00) err_n = 1'b1;
        if (shamt != '0) begin
          sh_n    = shamt;
          state_n = S_SHIFT;
        end else begin
          q_n     = qa_c[W-1:0];
          r_n     = rem_c[W-1:0];
          state_n = S_DONE;
        end
      end
      S_SHIFT: begin
        rem_n = rem_sh;
        sh_n  = sh - 1'b1;
        if (sh == SW'(1)) begin
          q_n     = qa[W-1:0];
          r_n     = rem_sh[W-1:0];
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= S_IDLE;
      qa    <= '0;
      qb    <= '0;
      rem   <= '0;
      dsr   <= '0;
      shamt <= '0;
      sh    <= '0;
      cnt   <= '0;
      ERR   <= 1'b0;
      Q     <= '0;
      R     <= '0;
    end else begin
      state <= state_n;
      qa    <= qa_n;
      qb    <= qb_n;
      rem   <= rem_n;
      dsr   <= dsr_n;
      shamt <= shamt_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      ERR   <= err_n;
      Q     <= q_n;
      R     <= r_n;
    end
  end

  assign DIG_READY = (state == S_ACCUM);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_DONE);

endmodule

// File: tb/tb_srt_qconv.sv
// Directed bench for srt_qconv at W=8, NDIG=4.
module tb_srt_qconv;

  localparam int W  = 8;
  localparam int SW = 7;

  localparam logic [2:0] DZ = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] M1 = 3'b101;
  localparam logic [2:0] IL = 3'b100;

  logic          CLK = 1'b0;
  logic          RSTN, START, DIG_VALID, DIG_LAST;
  logic [W-1:0]  DSR_N;
  logic [SW-1:0] SHAMT;
  logic [2:0]    DIG;
  logic [W:0]    REM_IN;
  logic          DIG_READY, BUSY, DONE, ERR;
  logic [W-1:0]  Q, R;

  int n_run  = 0;
  int n_fail = 0;
  int lat;

  srt_qconv #(.W(W), .NDIG(4), .SW(SW)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START),
    .DSR_N(DSR_N), .SHAMT(SHAMT),
    .DIG_VALID(DIG_VALID), .DIG(DIG),
    .DIG_LAST(DIG_LAST), .REM_IN(REM_IN),
    .DIG_READY(DIG_READY), .BUSY(BUSY),
    .Q(Q), .R(R), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [W-1:0] dsr,
                       input logic [SW-1:0] sh);
    START = 1'b1;
    DSR_N = dsr;
    SHAMT = sh;
    step();
    START = 1'b0;
  endtask

  task automatic send(input logic [2:0] d,
                      input logic last,
                      input logic [W:0] rem);
    DIG_VALID = 1'b1;
    DIG       = d;
    DIG_LAST  = last;
    REM_IN    = rem;
    step();
    DIG_VALID = 1'b0;
    DIG_LAST  = 1'b0;
    DIG       = DZ;
  endtask

  // Returns cycles from last accepted digit to the DONE cycle.
  task automatic wait_done(output int l);
    l = 1;
    while (!DONE && l < 40) begin
      step();
      l++;
    end
    if (!DONE) check("done_timeout", 0, 1);
  endtask

  task automatic after_done(input string tag);
    step();
    check({tag, "_done_1cyc"}, DONE, 0);
    check({tag, "_idle"}, BUSY, 0);
  endtask

  initial begin
    RSTN = 1'b0; START = 1'b0; DIG_VALID = 1'b0;
    DIG_LAST = 1'b0; DIG = DZ; DSR_N = '0;
    SHAMT = '0; REM_IN = '0;
    step(); step();
    RSTN = 1'b1;
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_busy", BUSY, 0);
    check("rst_rdy", DIG_READY, 0);

    // all +1 digits
    start(8'h80, 7'd0);
    check("t1_busy", BUSY, 1);
    check("t1_rdy", DIG_READY, 1);
    send(P1, 0, 9'd0);
    send(P1, 0, 9'd0);
    send(P1, 0, 9'd0);
    send(P1, 1, 9'd5);
    check("t1_rdy_corr", DIG_READY, 0);
    wait_done(lat);
    check("t1_lat", lat, 2);
    check("t1_q", Q, 85);
    check("t1_r", R, 5);
    check("t1_err", ERR, 0);
    after_done("t1");
    check("t1_q_hold", Q, 85);

    // mixed signed digits
    start(8'h80, 7'd0);
    send(P1, 0, 9'd0);
    send(M1, 0, 9'd0);
    send(DZ, 0, 9'd0);
    send(P2, 1, 9'd0);
    wait_done(lat);
    check("t2_q", Q, 50);
    check("t2_r", R, 0);
    check("t2_err", ERR, 0);
    after_done("t2");

    // negative remainder, de-normalize by 3
    start(8'h90, 7'd3);
    send(P2, 0, 9'd0);
    send(DZ, 0, 9'd0);
    send(DZ, 0, 9'd0);
    send(DZ, 1, 9'h1FD);
    wait_done(lat);
    check("t3_lat", lat, 5);
    check("t3_q", Q, 127);
    check("t3_r", R, 17);
    check("t3_err", ERR, 0);
    after_done("t3");

    // DIG_LAST on 2nd digit
    start(8'h80, 7'd0);
    send(P1, 0, 9'd0);
    send(P1, 1, 9'd0);
    check("t4_err_early", ERR, 1);
    wait_done(lat);
    check("t4_lat", lat, 2);
    check("t4_q", Q, 5);
    check("t4_err", ERR, 1);
    after_done("t4");

    // negative quotient
    start(8'h80, 7'd0);
    check("t5_err_clr", ERR, 0);
    send(M1, 0, 9'd0);
    send(DZ, 0, 9'd0);
    send(DZ, 0, 9'd0);
    send(DZ, 1, 9'd0);
    wait_done(lat);
    check("t5_q", Q, 8'hC0);
    check("t5_err", ERR, 1);
    after_done("t5");

    // illegal code 100 decoded as 0
    start(8'h80, 7'd0);
    send(P1, 0, 9'd0);
    check("t6_err_pre", ERR, 0);
    send(IL, 0, 9'd0);
    check("t6_err_ill", ERR, 1);
    send(DZ, 0, 9'd0);
    send(P1, 1, 9'd0);
    wait_done(lat);
    check("t6_q", Q, 65);
    check("t6_err", ERR, 1);
    after_done("t6");

    // gaps between digits, stray START mid-accumulation
    start(8'h80, 7'd0);
    send(P1, 0, 9'd0);
    repeat (3) step();
    START = 1'b1; DSR_N = 8'hFF; SHAMT = 7'd5;
    send(M1, 0, 9'd0);
    START = 1'b0;
    repeat (3) step();
    send(DZ, 0, 9'd0);
    repeat (3) step();
    check("t7_rdy_gap", DIG_READY, 1);
    send(P2, 1, 9'd0);
    wait_done(lat);
    check("t7_lat", lat, 2);
    check("t7_q", Q, 50);
    check("t7_r", R, 0);
    check("t7_err", ERR, 0);
    after_done("t7");

    // reset mid-accumulation
    start(8'h80, 7'd0);
    send(P1, 0, 9'd0);
    send(IL, 0, 9'd0);
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    check("t8_q", Q, 0);
    check("t8_r", R, 0);
    check("t8_err", ERR, 0);
    check("t8_busy", BUSY, 0);
    check("t8_rdy", DIG_READY, 0);
    check("t8_done", DONE, 0);
    start(8'h80, 7'd0);
    send(P1, 0, 9'd0);
    send(P1, 0, 9'd0);
    send(P1, 0, 9'd0);
    send(P1, 1, 9'd5);
    wait_done(lat);
    check("t8_lat", lat, 2);
    check("t8_q2", Q, 85);
    check("t8_r2", R, 5);
    check("t8_err2", ERR, 0);
    after_done("t8");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
